clk_div_prog: RTL and testbench
===============================

Name: clk_div_prog

Overview:
- Runtime-programmable integer clock divider: generates `clk_out` = `clk_in` / N for N in [2, 2^DIV_W − 1].
- 50% duty cycle for both even and odd N; odd N uses a falling-edge trim flop.
- Also provides a one-cycle `tick` clock-enable strobe per output period, for logic that stays in the `clk_in` domain.
- Sits beside the receive path as the general replacement for fixed divide-by-4 generation (e.g. 100 MHz → 25 MHz, 50 MHz, 33.3 MHz, or slower MDIO-style clocks).

Parameters:
- DIV_W, 8, width of the divide-ratio input and internal counter.
- DEFAULT_DIV, 4, ratio in force after reset; must be in [2, 2^DIV_W − 1].

Ports:
- clk_in  input  1  source clock; all logic on posedge except the odd-trim flop (negedge).
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  run enable.
- div_val  input  DIV_W  requested divide ratio N.
- div_load  input  1  one-cycle strobe; samples `div_val`.
- clk_out  output  1  divided clock.
- tick  output  1  one-`clk_in`-cycle pulse at the start of each output period.
- cur_div  output  DIV_W  ratio currently in force.
- running  output  1  divider active.
- cfg_err  output  1  one-cycle pulse when `div_load` carries an illegal ratio.

Behaviour:
- Reset (async, `rst_n` = 0):
  - cnt = 0, `cur_div` = DEFAULT_DIV, pending = none.
  - `clk_out` = 0, `tick` = 0, `running` = 0, `cfg_err` = 0, trim flop = 0.
  - Reset asserted mid-period forces `clk_out` low immediately; there is no completion of the period.
- States:
  - IDLE: `running` = 0, `clk_out` = 0, cnt held at 0.
  - RUN: `running` = 1.
  - STOPPING: `running` = 1; finishing the current period.
- Transitions:
  - IDLE → RUN on a posedge sampling `en` = 1. At that same edge, the period starts: cnt = 0, `clk_out` rises, `tick` = 1 for that cycle.
  - RUN → STOPPING when `en` is sampled 0.
  - STOPPING → IDLE at the period's last cycle (cnt = `cur_div` − 1).
  - STOPPING → RUN, without a gap, if `en` returns to 1 before the period completes.
  - A stop therefore never truncates a high or low phase.
- Counting (RUN/STOPPING):
  - cnt increments 0 … N−1, then wraps to 0.
  - `tick` = 1 exactly in the cycles with cnt = 0.
- Posedge output term: pos_q = 1 for cnt < ceil(N/2).
- Even N: `clk_out` = pos_q, giving N/2 cycles high and N/2 low.
- Odd N:
  - neg_q = pos_q re-registered on the negedge of `clk_in`.
  - `clk_out` = pos_q AND neg_q, giving a high phase of N/2 cycles (half-cycle resolution), rising half a cycle after the cnt = 0 posedge.
  - `tick` still aligns to the cnt = 0 cycle.
- Ratio change:
  - `div_load` = 1 with 2 ≤ `div_val`: the value is stored as pending.
  - The pending value is applied at the next wrap (cnt N−1 → 0); `cur_div` updates on that same edge.
  - In IDLE, the pending value is applied immediately.
  - A new load before the wrap overwrites the pending value (last one wins).
  - Result: no runt or stretched phase on `clk_out`.
- Illegal ratio:
  - `div_val` ∈ {0, 1} with `div_load` = 1: `cfg_err` pulses 1 for one cycle.
  - The pending value is unchanged and `cur_div` is unchanged.
- Simultaneous events:
  - `div_load` at the wrap edge: the previous pending value is applied at this wrap; the new value waits for the next wrap.
  - `en` fall and `div_load` together: the load is still captured, and applies on restart.
- Width: `cur_div` = 2^DIV_W − 1 is legal; cnt never overflows.
- Constraint: `clk_out` is a generated clock and must be constrained as such. Downstream logic should prefer `tick`.

Test Plan:
- Release reset with `en` = 1, N = DEFAULT_DIV = 4 → `clk_out` pattern 1,1,0,0 repeating (period 4 `clk_in`); `tick` high every 4th cycle aligned to the rising edge; `cur_div` = 4.
- Load 3 mid-period at N = 4 → current period completes as 2 high / 2 low; next period has period 3 and high time 1.5 cycles (measured edge-to-edge); no glitch; `cur_div` changes exactly at the wrap.
- Load 0 and then 1 → `cfg_err` pulses once per load; `cur_div` and `clk_out` waveform unchanged.
- N = 10, drop `en` at cnt = 2 → `clk_out` completes the 5-high / 5-low period, then holds 0; `running` = 0 after cnt = 9; `tick` stops. Re-raise `en` → restart with `tick` and a rising edge on the first sampled edge.
- N = 255 (max, DIV_W = 8) → period 255, high 127.5 cycles, cnt wraps cleanly. N = 2 → toggle every cycle.
- Assert `rst_n` = 0 asynchronously mid high phase at N = 6 → `clk_out`, `tick`, and `running` go 0 immediately with no clock edge; `cur_div` returns to 4.

Source files
------------

// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: configuration/status bundle for clk_div_prog.
//   div_val  - requested divide ratio N (driven by master)
//   div_load - one-cycle strobe that samples div_val (driven by master)
//   cur_div  - ratio currently in force (driven by divider)
//   cfg_err  - one-cycle pulse on an illegal ratio load (driven by divider)
interface clk_div_prog_if #(
  parameter int DIV_W = 8
);
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic [DIV_W-1:0] cur_div;
  logic             cfg_err;

  modport master (
    output div_val,
    output div_load,
    input  cur_div,
    input  cfg_err
  );

  modport slave (
    input  div_val,
    input  div_load,
    output cur_div,
    output cfg_err
  );
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable integer clock divider, clk_out = clk_in / N,
// N in [2, 2^DIV_W-1], 50% duty for even and odd N, plus a one-cycle tick
// strobe at the start of every output period for clk_in-domain logic.
//   clk_in  - source clock (posedge logic, one negedge trim flop)
//   rst_n   - asynchronous active-low reset
//   en      - run enable; dropping it finishes the current period first
//   cfg     - ratio load / status bundle (div_val, div_load, cur_div, cfg_err)
//   clk_out - divided clock (must be constrained as a generated clock)
//   tick    - high in the cnt = 0 cycle of each output period
//   running - divider active (RUN or STOPPING)
//
// state    | meaning
// IDLE     | stopped, clk_out low, cnt held at 0, loads apply at once
// RUN      | counting, en sampled high
// STOPPING | en sampled low, finishing the current period before IDLE
module clk_div_prog #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         en,
  clk_div_prog_if.slave cfg,
  output logic         clk_out,
  output logic         tick,
  output logic         running
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pos_q, pos_d;
  logic             tick_q, tick_d;
  logic             running_q, running_d;
  logic             cfg_err_q, cfg_err_d;
  logic             neg_q;

  logic             load_ok;
  logic             load_bad;
  logic             last_cnt;
  logic [DIV_W-1:0] half_d;

  // A ratio is legal when any bit above bit 0 is set, i.e. N >= 2.
  assign load_ok  = cfg.div_load && (cfg.div_val[DIV_W-1:1] != '0);
  assign load_bad = cfg.div_load && (cfg.div_val[DIV_W-1:1] == '0);
  assign last_cnt = (cnt_q == (cur_div_q - ONE));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cfg_err_d  = load_bad;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Nothing is being generated, so a ratio takes effect immediately.
        if (pend_vld_q) begin
          cur_div_d  = pend_q;
          pend_vld_d = 1'b0;
        end
        if (load_ok) begin
          cur_div_d  = cfg.div_val;
          pend_vld_d = 1'b0;
        end
        if (en) begin
          state_d = RUN;
        end
      end

      RUN, STOPPING: begin
        if (last_cnt) begin
          // Period boundary: the only place the ratio may change or the
          // divider may stop, so no phase is ever cut short or stretched.
          cnt_d = '0;
          if (pend_vld_q) begin
            cur_div_d  = pend_q;
            pend_vld_d = 1'b0;
          end
          state_d = en ? RUN : IDLE;
        end else begin
          cnt_d   = cnt_q + ONE;
          state_d = en ? RUN : STOPPING;
        end
        // A load on the wrap edge waits for the following wrap.
        if (load_ok) begin
          pend_d     = cfg.div_val;
          pend_vld_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // ceil(N/2) cycles of high posedge term; fits in DIV_W bits.
    half_d    = (cur_div_d >> 1) + DIV_W'(cur_div_d[0]);
    running_d = (state_d != IDLE);
    tick_d    = running_d && (cnt_d == '0);
    pos_d     = running_d && (cnt_d < half_d);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DEF_DIV;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
      running_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      running_q  <= running_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Half-cycle delayed copy of pos_q; ANDing it in trims the odd-N high
  // phase by half a cycle on the rising side, giving exactly N/2 cycles.
  always_ff @(negedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out     = cur_div_q[0] ? (pos_q & neg_q) : pos_q;
  assign tick        = tick_q;
  assign running     = running_q;
  assign cfg.cur_div = cur_div_q;
  assign cfg.cfg_err = cfg_err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
module tb_clk_div_prog;

  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 4;

  logic clk_in = 1'b0;
  logic rst_n  = 1'b1;
  logic en;
  logic clk_out, tick, running;

  clk_div_prog_if #(.DIV_W(DIV_W)) cfg_if ();

  clk_div_prog #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg_if),
    .clk_out (clk_out),
    .tick    (tick),
    .running (running)
  );

  initial forever #5 clk_in = ~clk_in;

  typedef struct {
    int tick;
    int running;
    int cur;
    int err;
    int hi0;   // clk_out in first half of the cycle
    int hi1;   // clk_out in second half of the cycle
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: period position, ratio in force, pending ratio.
  int   m_run, m_pos, m_n, m_pend, m_pend_v;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_n = DEFAULT_DIV; m_pend = 0; m_pend_v = 0;
  endtask

  // One clk_in cycle: advance the model with the inputs the DUT samples at
  // this posedge, queue the expected outputs, then release the load strobe.
  task automatic step();
    exp_t e;
    int   err, legal, dv, s, h;
    @(posedge clk_in);
    err = 0;
    if (!rst_n) begin
      model_reset();
    end else begin
      dv    = int'(cfg_if.div_val);
      legal = (cfg_if.div_load && dv >= 2) ? 1 : 0;
      err   = (cfg_if.div_load && dv < 2) ? 1 : 0;
      if (m_run == 0) begin
        if (m_pend_v != 0) begin m_n = m_pend; m_pend_v = 0; end
        if (legal != 0) m_n = dv;
        if (en) begin m_run = 1; m_pos = 0; end
      end else begin
        if (m_pos == m_n - 1) begin
          if (m_pend_v != 0) begin m_n = m_pend; m_pend_v = 0; end
          m_pos = 0;
          if (!en) m_run = 0;
        end else begin
          m_pos++;
        end
        if (legal != 0) begin m_pend = dv; m_pend_v = 1; end
      end
    end
    // High window measured in half cycles from the period start: N half
    // cycles long, starting half a cycle late for odd N.
    s = m_n % 2;
    h = 2 * m_pos;
    e.tick    = (m_run != 0 && m_pos == 0) ? 1 : 0;
    e.running = m_run;
    e.cur     = m_n;
    e.err     = err;
    e.hi0     = (m_run != 0 && h >= s && h < s + m_n) ? 1 : 0;
    e.hi1     = (m_run != 0 && h + 1 >= s && h + 1 < s + m_n) ? 1 : 0;
    exp_q.push_back(e);
    #2;
    cfg_if.div_load = 1'b0;
  endtask

  task automatic wait_state(input int n, input int p, input int maxc, input string name);
    for (int i = 0; i < maxc && !(m_run == 1 && m_n == n && m_pos == p); i++) step();
    chk(name, (m_run == 1 && m_n == n && m_pos == p) ? 1 : 0, 1);
  endtask

  task automatic load(input int v);
    cfg_if.div_val  = DIV_W'(v);
    cfg_if.div_load = 1'b1;
  endtask

  // Monitor: compares every queued expectation against the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tick",       int'(tick),           e.tick);
        chk("running",    int'(running),        e.running);
        chk("cur_div",    int'(cfg_if.cur_div), e.cur);
        chk("cfg_err",    int'(cfg_if.cfg_err), e.err);
        chk("clk_out_h0", int'(clk_out),        e.hi0);
        @(negedge clk_in);
        #1;
        chk("clk_out_h1", int'(clk_out),        e.hi1);
      end
    end
  end

  initial begin
    int r;
    en = 1'b1;
    cfg_if.div_val  = '0;
    cfg_if.div_load = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (12) step();

    // Ratio change 4 -> 3 mid-period.
    wait_state(4, 1, 10, "reach_n4_pos1");
    load(3);
    repeat (12) step();

    // Illegal ratios.
    load(0);
    repeat (4) step();
    load(1);
    repeat (4) step();

    // N = 10, stop mid-period, then restart.
    load(10);
    wait_state(10, 2, 30, "reach_n10_pos2");
    en = 1'b0;
    repeat (15) step();
    en = 1'b1;
    repeat (12) step();

    // Extremes.
    load(255);
    wait_state(255, 0, 40, "reach_n255");
    repeat (520) step();
    load(2);
    wait_state(2, 0, 300, "reach_n2");
    repeat (8) step();

    // Random enable and load traffic.
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 24) == 0) en = ~en;
      if ($urandom_range(0, 14) == 0) begin
        r = int'($urandom_range(0, 9));
        if (r <= 1)      load(r);
        else if (r <= 6) load(int'($urandom_range(2, 12)));
        else if (r <= 8) load(int'($urandom_range(13, 40)));
        else             load(int'($urandom_range(250, 255)));
      end
      step();
    end

    // Asynchronous reset in the high phase at N = 6.
    en = 1'b1;
    load(6);
    wait_state(6, 1, 600, "reach_n6_pos1");
    @(negedge clk_in);
    #2;
    chk("pre_rst_clk_out", int'(clk_out), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_clk_out", int'(clk_out), 0);
    chk("async_rst_tick",    int'(tick), 0);
    chk("async_rst_running", int'(running), 0);
    chk("async_rst_cur_div", int'(cfg_if.cur_div), DEFAULT_DIV);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (10) step();

    @(negedge clk_in);
    #3;
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
